// File: rtl/aibnd_clkgate_ctrl_if.sv
// Handshake bundle between a gated-clock consumer and its enable sequencer.
// The consumer (master) raises the request/override and observes the gate
// enable, the acknowledge and the busy indication.
interface aibnd_clkgate_ctrl_if;
  logic clk_req;   // asynchronous level request for the gated clock
  logic force_on;  // asynchronous quasi-static override, holds the enable on
  logic en;        // gate enable to the NAND2, launched on the falling edge
  logic clk_ack;   // gated clock is stable and usable
  logic busy;      // sequencer is in any state other than OFF

  modport master (
    output clk_req,
    output force_on,
    input  en,
    input  clk_ack,
    input  busy
  );

  modport slave (
    input  clk_req,
    input  force_on,
    output en,
    output clk_ack,
    output busy
  );
endinterface

// File: rtl/aibnd_clkgate_ctrl.sv
// Enable sequencer for an AIB NAND2 clock gate. Synchronises the request and
// the override, raises the enable, acknowledges after a wake-up interval and
// withdraws the enable after an idle hysteresis. The enable handed to the gate
// is re-timed on the falling edge so it only moves while clk is low.
module aibnd_clkgate_ctrl #(
  parameter int SYNC_STAGES = 2,  // synchronizer depth, at least 2
  parameter int WAKE_CYC    = 4,  // enable-to-ack cycles, at least 1
  parameter int IDLE_CYC    = 8,  // idle cycles before the enable drops, at least 1
  parameter int CNT_W       = 4   // 2**CNT_W must exceed max(WAKE_CYC, IDLE_CYC)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vccl_aibnd,
  input  logic                 vssl_aibnd,
  aibnd_clkgate_ctrl_if.slave  gate_if
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYC - 1);

  // Supply pins carry no logic; fold them into a sink so they stay connected.
  logic unused_pwr;
  assign unused_pwr = vccl_aibnd & vssl_aibnd;

  logic [SYNC_STAGES-1:0] req_sync_q;
  logic [SYNC_STAGES-1:0] frc_sync_q;
  logic                   req_s;
  logic                   frc_s;
  logic                   want;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   en_q, en_d;
  logic                   ack_q, ack_d;
  logic                   en_neg_q;

  // Multi-flop synchronizers for the asynchronous request and override.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_sync_q <= '0;
      frc_sync_q <= '0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], gate_if.clk_req};
      frc_sync_q <= {frc_sync_q[SYNC_STAGES-2:0], gate_if.force_on};
    end
  end

  assign req_s = req_sync_q[SYNC_STAGES-1];
  assign frc_s = frc_sync_q[SYNC_STAGES-1];
  assign want  = req_s | frc_s;

  // State, shared interval counter and the posedge enable/ack registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
    end
  end

  // Next-state logic: WAKE always runs to completion; in HOLD a returning
  // request takes priority over an expiring idle count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    ack_d   = ack_q;
    case (state_q)
      ST_OFF: begin
        en_d  = 1'b0;
        ack_d = 1'b0;
        cnt_d = '0;
        if (want) begin
          state_d = ST_WAKE;
          en_d    = 1'b1;
        end
      end
      ST_WAKE: begin
        en_d  = 1'b1;
        ack_d = 1'b0;
        if (cnt_q == WAKE_LAST) begin
          state_d = ST_ON;
          ack_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ON: begin
        en_d  = 1'b1;
        ack_d = 1'b1;
        cnt_d = '0;
        if (!want) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        en_d  = 1'b1;
        ack_d = 1'b1;
        if (want) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end else if (cnt_q == IDLE_LAST) begin
          state_d = ST_OFF;
          en_d    = 1'b0;
          ack_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_OFF;
        en_d    = 1'b0;
        ack_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // Falling-edge re-time of the enable so the NAND2 input moves only while
  // clk is low; reset still closes the gate immediately in either phase.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_neg_q <= 1'b0;
    end else begin
      en_neg_q <= en_q;
    end
  end

  assign gate_if.en      = en_neg_q;
  assign gate_if.clk_ack = ack_q;
  assign gate_if.busy    = (state_q != ST_OFF);

endmodule

// File: tb/tb_aibnd_clkgate_ctrl.sv
// Scoreboard bench for the clock-gate enable sequencer. Stimulus pushes the
// expected output edges (value and absolute time) into one queue per output;
// independent monitors pop and compare whenever an output actually changes.
module tb_aibnd_clkgate_ctrl;

  localparam time HALF = 5;
  localparam time PER  = 10;

  typedef struct {
    logic val;
    time  t;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic vccl  = 1'b1;
  logic vssl  = 1'b0;
  bit   mon_on = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  ev_t q_en[$];
  ev_t q_ack[$];
  ev_t q_busy[$];

  aibnd_clkgate_ctrl_if gate_if();

  aibnd_clkgate_ctrl #(
    .SYNC_STAGES(2),
    .WAKE_CYC   (4),
    .IDLE_CYC   (8),
    .CNT_W      (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vccl_aibnd(vccl),
    .vssl_aibnd(vssl),
    .gate_if   (gate_if)
  );

  always #HALF clk = ~clk;

  // Stimulus is launched on a falling edge at time t0, so posedge k lies at
  // t0 + k*PER - HALF and the falling edge after it at t0 + k*PER.
  function automatic time pos_t(time t0, int k);
    return t0 + time'(k) * PER - HALF;
  endfunction

  function automatic time neg_t(time t0, int k);
    return t0 + time'(k) * PER;
  endfunction

  task automatic push_ev(int which, logic v, time t);
    ev_t e;
    e.val = v;
    e.t   = t;
    case (which)
      0:       q_en.push_back(e);
      1:       q_ack.push_back(e);
      default: q_busy.push_back(e);
    endcase
  endtask

  task automatic cmp_ev(string nm, logic v, ev_t e);
    vectors++;
    if (v !== e.val || $time != e.t) begin
      miscompares++;
      $display("FAIL %s edge: got %b at %0t, required %b at %0t", nm, v, $time, e.val, e.t);
    end else begin
      $display("ok   %s -> %b at %0t", nm, v, $time);
    end
  endtask

  task automatic unexpected(string nm, logic v);
    vectors++;
    miscompares++;
    $display("FAIL %s edge: got change to %b at %0t, required no change", nm, v, $time);
  endtask

  // Every expected edge must have been consumed by the end of a scenario.
  task automatic drain_check(string tag);
    vectors++;
    if (q_en.size() != 0) begin
      miscompares++;
      $display("FAIL %s drain_en: got %0d pending edges, required 0", tag, q_en.size());
    end
    vectors++;
    if (q_ack.size() != 0) begin
      miscompares++;
      $display("FAIL %s drain_ack: got %0d pending edges, required 0", tag, q_ack.size());
    end
    vectors++;
    if (q_busy.size() != 0) begin
      miscompares++;
      $display("FAIL %s drain_busy: got %0d pending edges, required 0", tag, q_busy.size());
    end
    q_en.delete();
    q_ack.delete();
    q_busy.delete();
    $display("ok   %s scenario drained at %0t", tag, $time);
  endtask

  task automatic start(output time t0);
    @(negedge clk);
    t0 = $time;
  endtask

  task automatic set_src(bit use_force, logic v);
    if (use_force) gate_if.force_on = v;
    else           gate_if.clk_req  = v;
  endtask

  // OFF -> WAKE at posedge 3, en at the following negedge, ack at posedge 7.
  task automatic do_assert(bit use_force, string tag, int hold_cyc);
    time t0;
    start(t0);
    set_src(use_force, 1'b1);
    push_ev(2, 1'b1, pos_t(t0, 3));
    push_ev(0, 1'b1, neg_t(t0, 3));
    push_ev(1, 1'b1, pos_t(t0, 7));
    repeat (hold_cyc) @(negedge clk);
    drain_check(tag);
  endtask

  // ON -> HOLD at posedge 3, OFF with ack/busy low at posedge 11, en at the next negedge.
  task automatic do_release(bit use_force, string tag);
    time t0;
    start(t0);
    set_src(use_force, 1'b0);
    push_ev(1, 1'b0, pos_t(t0, 11));
    push_ev(2, 1'b0, pos_t(t0, 11));
    push_ev(0, 1'b0, neg_t(t0, 11));
    repeat (14) @(negedge clk);
    drain_check(tag);
  endtask

  // Drop the request, re-raise it after rise_neg falling edges; no output may move.
  task automatic do_rerequest(int rise_neg, string tag);
    time t0;
    start(t0);
    gate_if.clk_req = 1'b0;
    repeat (rise_neg) @(negedge clk);
    gate_if.clk_req = 1'b1;
    repeat (15) @(negedge clk);
    drain_check(tag);
  endtask

  // Monitor: gate enable, also checking it only moves while clk is low.
  initial begin
    ev_t e;
    wait (mon_on);
    forever begin
      @(gate_if.en);
      if (q_en.size() == 0) unexpected("en", gate_if.en);
      else begin
        e = q_en.pop_front();
        cmp_ev("en", gate_if.en, e);
      end
      if (rst_n) begin
        vectors++;
        if (clk !== 1'b0) begin
          miscompares++;
          $display("FAIL en_phase: got clk=%b at en change %0t, required clk=0", clk, $time);
        end
      end
    end
  end

  // Monitor: acknowledge.
  initial begin
    ev_t e;
    wait (mon_on);
    forever begin
      @(gate_if.clk_ack);
      if (q_ack.size() == 0) unexpected("clk_ack", gate_if.clk_ack);
      else begin
        e = q_ack.pop_front();
        cmp_ev("clk_ack", gate_if.clk_ack, e);
      end
    end
  end

  // Monitor: busy.
  initial begin
    ev_t e;
    wait (mon_on);
    forever begin
      @(gate_if.busy);
      if (q_busy.size() == 0) unexpected("busy", gate_if.busy);
      else begin
        e = q_busy.pop_front();
        cmp_ev("busy", gate_if.busy, e);
      end
    end
  end

  initial begin
    time t0;
    time t1;
    gate_if.clk_req  = 1'b0;
    gate_if.force_on = 1'b0;

    // Reset, then 20 idle cycles: no output edge is expected at all.
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    mon_on = 1'b1;
    repeat (20) @(negedge clk);
    drain_check("idle");

    // Plain request and release timing.
    do_assert(1'b0, "request", 10);
    do_release(1'b0, "release");

    // Re-request landing at HOLD cnt=5: back to ON, nothing drops.
    do_assert(1'b0, "request2", 10);
    do_rerequest(6, "rereq_cnt5");

    // Re-request landing exactly on HOLD expiry: the request wins.
    do_rerequest(8, "rereq_expiry");
    do_release(1'b0, "release2");

    // Override alone brings the gate up and holds it indefinitely.
    do_assert(1'b1, "force_on", 40);
    do_release(1'b1, "force_off");

    // Reset mid-WAKE while clk is high, then the full latency restarts.
    start(t0);
    gate_if.clk_req = 1'b1;
    push_ev(2, 1'b1, pos_t(t0, 3));
    push_ev(0, 1'b1, neg_t(t0, 3));
    push_ev(2, 1'b0, t0 + 37);
    push_ev(0, 1'b0, t0 + 37);
    #37;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    t1 = $time;
    push_ev(2, 1'b1, pos_t(t1, 3));
    push_ev(0, 1'b1, neg_t(t1, 3));
    push_ev(1, 1'b1, pos_t(t1, 7));
    repeat (10) @(negedge clk);
    drain_check("reset_mid_wake");
    do_release(1'b0, "release3");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
